uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 114 +++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // 50 MHz core clock / 115200 baud
    localparam int BAUD_DIV_DEF = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, preset high (line idle).
// Latency: 2 clk from pin change to sync_bit change.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), async_bit (raw pin), sync_bit (clk-domain copy).
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta;

    // Preset to 1 so a reset never looks like a start bit on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b1;
            sync_bit <= 1'b1;
        end else begin
            meta     <= async_bit;
            sync_bit <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one byte holding register with rdy/frm_err flags.
// Latency: rdy rises BAUD_DIV/2 + 9*BAUD_DIV + 3 clk after the RX pin falls.
// Backpressure: none; an unconsumed byte is overwritten by the next good frame.
// Ports: clk, rst_n (async active-low), RX (serial in, idle high), clr_rdy (consumer ack),
//        rx_data (last good byte), rdy (new byte pending), frm_err (last stop bit was low).
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int              CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BAUD_DIV);

    logic             rx_s;
    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic             expire;

    rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_bit (RX),
        .sync_bit  (rx_s)
    );

    // Expiry fires on the clock the counter steps 1 -> 0, so a load of N gives
    // exactly N clocks to the next sample point.
    assign expire = (baud_cnt <= CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            // Placed first so a set from the STOP branch below overrides it.
            if (clr_rdy)
                rdy <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= HALF;
                        rdy      <= 1'b0;
                        frm_err  <= 1'b0;
                    end
                end

                START: begin
                    if (expire) begin
                        if (!rx_s) begin
                            state    <= DATA;
                            baud_cnt <= FULL;
                            bit_cnt  <= '0;
                        end else begin
                            // Line went back high mid start bit: glitch, drop it.
                            state    <= IDLE;
                            baud_cnt <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end

                DATA: begin
                    if (expire) begin
                        shift    <= {rx_s, shift[7:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        baud_cnt <= FULL;
                        if (bit_cnt == 4'd7)
                            state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end

                STOP: begin
                    if (expire) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        if (rx_s) begin
                            rx_data <= shift;
                            rdy     <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default bit timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BD = BAUD_DIV_DEF;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       RX      = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fall_cyc = 0;

    // Monitor state, sampled on the falling edge.
    logic       rdy_q       = 1'b0;
    logic       frm_q       = 1'b0;
    int         rise_cnt    = 0;
    int         rise_cyc    = 0;
    int         hi_cnt      = 0;
    int         frm_cnt     = 0;
    logic       frm_rdy_at  = 1'b0;
    logic [7:0] frm_data_at = 8'h00;

    uart_rx #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rdy_q <= rdy;
        frm_q <= frm_err;
        if (rdy && !rdy_q) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (rdy)
            hi_cnt <= hi_cnt + 1;
        if (frm_err && !frm_q) begin
            frm_cnt     <= frm_cnt + 1;
            frm_rdy_at  <= rdy;
            frm_data_at <= rx_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        tick(BD);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_b);
        RX = 1'b0;
        fall_cyc = cyc;
        tick(BD);
        for (int i = 0; i < 8; i++)
            send_bit(d[i]);
        send_bit(stop_b);
        RX = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RX    = 1'b1;
        tick(3);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
        total++; if (rdy !== 1'b0)      begin bad++; $display("FAIL reset_rdy got=%b want=0", rdy); end
        total++; if (frm_err !== 1'b0)  begin bad++; $display("FAIL reset_frm got=%b want=0", frm_err); end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_good_byte();
        int r0;
        int lat;
        r0 = rise_cnt;
        send_byte(8'hA5, 1'b1);
        tick(20);
        lat = rise_cyc - fall_cyc;
        total++; if (rise_cnt !== r0 + 1) begin bad++; $display("FAIL a5_pulses got=%0d want=%0d", rise_cnt - r0, 1); end
        total++; if (lat < 4124 || lat > 4128) begin bad++; $display("FAIL a5_latency got=%0d want=4126+/-2", lat); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", rx_data); end
        total++; if (frm_err !== 1'b0)  begin bad++; $display("FAIL a5_frm got=%b want=0", frm_err); end
        total++; if (rdy !== 1'b1)      begin bad++; $display("FAIL a5_rdy_hold got=%b want=1", rdy); end
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        tick(1);
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL a5_clr got=%b want=0", rdy); end
        // Ack with nothing pending must be harmless.
        clr_rdy = 1'b1;
        tick(3);
        clr_rdy = 1'b0;
        tick(1);
        total++; if (rdy !== 1'b0)      begin bad++; $display("FAIL idle_clr_rdy got=%b want=0", rdy); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL idle_clr_data got=%h want=a5", rx_data); end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rise_cnt;
        RX = 1'b0;
        tick(100);
        RX = 1'b1;
        tick(600);
        total++; if (rdy !== 1'b0)      begin bad++; $display("FAIL glitch_rdy got=%b want=0", rdy); end
        total++; if (rise_cnt !== r0)   begin bad++; $display("FAIL glitch_pulses got=%0d want=0", rise_cnt - r0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL glitch_data got=%h want=a5", rx_data); end
        total++; if (frm_err !== 1'b0)  begin bad++; $display("FAIL glitch_frm got=%b want=0", frm_err); end
    endtask

    task automatic test_frame_err();
        int r0;
        int f0;
        r0 = rise_cnt;
        f0 = frm_cnt;
        send_byte(8'h3C, 1'b0);
        tick(600);
        total++; if (frm_cnt !== f0 + 1)    begin bad++; $display("FAIL ferr_flag got=%0d want=1 rises", frm_cnt - f0); end
        total++; if (frm_rdy_at !== 1'b0)   begin bad++; $display("FAIL ferr_rdy_at got=%b want=0", frm_rdy_at); end
        total++; if (frm_data_at !== 8'hA5) begin bad++; $display("FAIL ferr_data_at got=%h want=a5", frm_data_at); end
        total++; if (rise_cnt !== r0)       begin bad++; $display("FAIL ferr_pulses got=%0d want=0", rise_cnt - r0); end
        total++; if (rx_data !== 8'hA5)     begin bad++; $display("FAIL ferr_data got=%h want=a5", rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [2];
        int r0;
        got[0] = 8'h00;
        got[1] = 8'h00;
        r0 = rise_cnt;
        fork
            begin
                send_byte(8'h01, 1'b1);
                send_byte(8'hFE, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int w;
                    w = 0;
                    while (!rdy && w < 6000) begin
                        tick(1);
                        w++;
                    end
                    if (!rdy) begin
                        total++; bad++;
                        $display("FAIL b2b_timeout frame=%0d got=no rdy want=rdy", k);
                    end else begin
                        got[k] = rx_data;
                        tick(10);
                        clr_rdy = 1'b1;
                        tick(1);
                        clr_rdy = 1'b0;
                    end
                end
            end
        join
        tick(20);
        total++; if (got[0] !== 8'h01)    begin bad++; $display("FAIL b2b_first got=%h want=01", got[0]); end
        total++; if (got[1] !== 8'hFE)    begin bad++; $display("FAIL b2b_second got=%h want=fe", got[1]); end
        total++; if (rise_cnt !== r0 + 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", rise_cnt - r0); end
    endtask

    task automatic test_clr_held();
        int r0;
        int h0;
        r0 = rise_cnt;
        h0 = hi_cnt;
        clr_rdy = 1'b1;
        send_byte(8'h55, 1'b1);
        tick(20);
        clr_rdy = 1'b0;
        tick(1);
        total++; if (rise_cnt !== r0 + 1) begin bad++; $display("FAIL held_pulses got=%0d want=1", rise_cnt - r0); end
        total++; if (hi_cnt !== h0 + 1)   begin bad++; $display("FAIL held_width got=%0d want=1", hi_cnt - h0); end
        total++; if (rx_data !== 8'h55)   begin bad++; $display("FAIL held_data got=%h want=55", rx_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int r0;
        d = 8'hC3;
        RX = 1'b0;
        tick(BD);
        for (int i = 0; i < 4; i++)
            send_bit(d[i]);
        RX = d[4];
        tick(200);
        rst_n = 1'b0;
        tick(2);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h want=00", rx_data); end
        total++; if (rdy !== 1'b0)      begin bad++; $display("FAIL mid_rst_rdy got=%b want=0", rdy); end
        total++; if (frm_err !== 1'b0)  begin bad++; $display("FAIL mid_rst_frm got=%b want=0", frm_err); end
        RX = 1'b1;
        tick(10);
        rst_n = 1'b1;
        tick(20);
        r0 = rise_cnt;
        send_byte(8'h81, 1'b1);
        tick(20);
        total++; if (rx_data !== 8'h81)   begin bad++; $display("FAIL post_rst_data got=%h want=81", rx_data); end
        total++; if (rdy !== 1'b1)        begin bad++; $display("FAIL post_rst_rdy got=%b want=1", rdy); end
        total++; if (frm_err !== 1'b0)    begin bad++; $display("FAIL post_rst_frm got=%b want=0", frm_err); end
        total++; if (rise_cnt !== r0 + 1) begin bad++; $display("FAIL post_rst_pulses got=%0d want=1", rise_cnt - r0); end
    endtask

    initial begin
        test_reset();
        test_good_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_clr_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
